// File: rtl/mem_ctrl_mc_if.sv
// Word-access request/completion bundle shared by all requester channels of mem_ctrl_mc.
interface mem_ctrl_mc_if #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 9,
  parameter int WIDTH      = 16,
  parameter int BE_WIDTH   = WIDTH / 8
);
  logic [NUM_CH-1:0]            valid;
  logic [NUM_CH-1:0]            wr_rd;
  logic [NUM_CH*ADDR_WIDTH-1:0] addr;
  logic [NUM_CH*WIDTH-1:0]      wdata;
  logic [NUM_CH*BE_WIDTH-1:0]   be;
  logic [NUM_CH-1:0]            ready;
  logic [NUM_CH-1:0]            err;
  logic [NUM_CH*WIDTH-1:0]      rdata;

  modport master (output valid, wr_rd, addr, wdata, be, input ready, err, rdata);
  modport slave  (input valid, wr_rd, addr, wdata, be, output ready, err, rdata);
endinterface

// File: rtl/mem_ctrl_mc.sv
// Multi-channel single-port RAM controller: round-robin grant, byte-enabled writes, wait states.
// Optional MEM_CLEAR_EN: zero the whole array after reset before servicing requests.
//
// state  | meaning
// IDLE   | waiting for any valid; grants next channel after last_grant
// ACCESS | wait-state countdown, access performed on the edge leaving at count 1
// DONE   | ready/err pulse for the granted channel, then back to IDLE
// CLEAR  | (MEM_CLEAR_EN only) writes zero to one address per cycle
module mem_ctrl_mc #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 512,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int NUM_CH      = 2,
  parameter int WAIT_CYCLES = 1,
  parameter int BE_WIDTH    = WIDTH / 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_ctrl_mc_if.slave  bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, CLEAR} state_t;

  state_t                   state;
  logic [CH_W-1:0]          last_grant;
  logic [CH_W-1:0]          grant;
  logic [CH_W-1:0]          next_grant;
  logic [CH_W-1:0]          cand;
  logic [3:0]               wait_cnt;
  logic                     lat_wr;
  logic [ADDR_WIDTH-1:0]    lat_addr;
  logic [WIDTH-1:0]         lat_wdata;
  logic [BE_WIDTH-1:0]      lat_be;
  logic [NUM_CH-1:0]        ready_q;
  logic [NUM_CH-1:0]        err_q;
  logic [NUM_CH*WIDTH-1:0]  rdata_q;
`ifdef MEM_CLEAR_EN
  logic [ADDR_WIDTH-1:0]    clr_addr;
`endif

  logic                     acc_wr;
  logic [ADDR_WIDTH-1:0]    acc_addr;
  logic [WIDTH-1:0]         acc_wdata;
  logic [BE_WIDTH-1:0]      acc_be;
  logic [CH_W-1:0]          acc_ch;
  logic                     acc_fire;
  logic                     acc_ok;
  logic                     any_valid;

  logic                     mem_we;
  logic [ADDR_WIDTH-1:0]    mem_idx;
  logic [WIDTH-1:0]         mem_wdata;
  logic [BE_WIDTH-1:0]      mem_mask;
  logic [WIDTH-1:0]         mem [DEPTH];

  assign any_valid = |bus.valid;

  // Descending scan so the nearest requester after last_grant wins.
  always_comb begin
    next_grant = last_grant;
    cand       = last_grant;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = CH_W'((int'(last_grant) + i) % NUM_CH);
      if (bus.valid[cand]) next_grant = cand;
    end
  end

  // With zero wait states the access happens straight from IDLE on the live inputs.
  always_comb begin
    acc_wr    = lat_wr;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    acc_be    = lat_be;
    acc_ch    = grant;
    if (state == IDLE) begin
      acc_wr    = bus.wr_rd[next_grant];
      acc_addr  = bus.addr[int'(next_grant)*ADDR_WIDTH +: ADDR_WIDTH];
      acc_wdata = bus.wdata[int'(next_grant)*WIDTH +: WIDTH];
      acc_be    = bus.be[int'(next_grant)*BE_WIDTH +: BE_WIDTH];
      acc_ch    = next_grant;
    end
    acc_fire = ((state == ACCESS) && (wait_cnt == 4'd1)) ||
               ((state == IDLE) && any_valid && (WAIT_CYCLES == 0));
    acc_ok   = (32'(acc_addr) < 32'(DEPTH));
  end

  always_comb begin
    mem_we    = rst_i && acc_fire && acc_wr && acc_ok;
    mem_idx   = acc_addr;
    mem_wdata = acc_wdata;
    mem_mask  = acc_be;
`ifdef MEM_CLEAR_EN
    if (state == CLEAR) begin
      mem_we    = rst_i;
      mem_idx   = clr_addr;
      mem_wdata = '0;
      mem_mask  = '1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (mem_we && mem_mask[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
`ifdef MEM_CLEAR_EN
      state    <= CLEAR;
      clr_addr <= '0;
`else
      state    <= IDLE;
`endif
      last_grant <= CH_W'(NUM_CH - 1);
      grant      <= '0;
      wait_cnt   <= '0;
      lat_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      ready_q    <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
    end else begin
      ready_q <= '0;
      err_q   <= '0;
      if (acc_fire) begin
        ready_q[acc_ch] <= 1'b1;
        err_q[acc_ch]   <= !acc_ok;
        if (!acc_wr) rdata_q[int'(acc_ch)*WIDTH +: WIDTH] <= acc_ok ? mem[acc_addr] : '0;
      end
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant     <= next_grant;
            lat_wr    <= acc_wr;
            lat_addr  <= acc_addr;
            lat_wdata <= acc_wdata;
            lat_be    <= acc_be;
            wait_cnt  <= 4'(WAIT_CYCLES);
            state     <= (WAIT_CYCLES == 0) ? DONE : ACCESS;
          end
        end
        ACCESS: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= DONE;
        end
        DONE: begin
          last_grant <= grant;
          state      <= IDLE;
        end
`ifdef MEM_CLEAR_EN
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == ADDR_WIDTH'(DEPTH - 1)) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_mem_ctrl_mc.sv
// Directed bench for mem_ctrl_mc: 2 channels, DEPTH 500, one wait state; MEM_CLEAR_EN adds the clear test.
module tb_mem_ctrl_mc;
  localparam int W     = 16;
  localparam int DEPTH = 500;
  localparam int AW    = 9;
  localparam int NCH   = 2;
  localparam int WAITC = 1;
  localparam int BW    = W / 8;
  localparam int BOUND = DEPTH + 50;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk_i = ~clk_i;

  mem_ctrl_mc_if #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .WIDTH(W), .BE_WIDTH(BW)) bus ();

  mem_ctrl_mc #(
    .WIDTH(W), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_CH(NCH),
    .WAIT_CYCLES(WAITC), .BE_WIDTH(BW)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_clear();
`ifdef MEM_CLEAR_EN
    repeat (DEPTH + 2) @(posedge clk_i);
    #1;
`endif
  endtask

  // Issue one request, wait for its completion, then step past DONE back into IDLE.
  task automatic do_req(input int ch, input logic wr, input logic [AW-1:0] a,
                        input logic [W-1:0] d, input logic [BW-1:0] be,
                        output int lat, output logic err, output logic [W-1:0] rd);
    bus.valid[ch]            = 1'b1;
    bus.wr_rd[ch]            = wr;
    bus.addr[ch*AW +: AW]    = a;
    bus.wdata[ch*W +: W]     = d;
    bus.be[ch*BW +: BW]      = be;
    lat = 0;
    for (int i = 0; i < BOUND; i++) begin
      @(posedge clk_i); #1;
      lat++;
      if (bus.ready[ch]) break;
    end
    check("completion_seen", {31'd0, bus.ready[ch]}, 32'd1);
    err = bus.err[ch];
    rd  = bus.rdata[ch*W +: W];
    bus.valid[ch] = 1'b0;
    @(posedge clk_i); #1;
    check("single_pulse", {30'd0, bus.ready}, 32'd0);
  endtask

  int          lat;
  logic        err;
  logic [W-1:0] rd;
  int          order [4];
  int          when  [4];
  int          n_done;
  int          cyc;
  logic        saw_ready;

  initial begin
    bus.valid = '0;
    bus.wr_rd = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.be    = '0;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", {30'd0, bus.ready}, 32'd0);
    check("rst_err",   {30'd0, bus.err},   32'd0);
    check("rst_rdata", bus.rdata,          32'd0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    wait_clear();

    do_req(0, 1'b1, 9'd5, 16'hA5C3, 2'b11, lat, err, rd);
    check("wr5_latency", lat, 32'd2);
    check("wr5_err", {31'd0, err}, 32'd0);
    do_req(0, 1'b0, 9'd5, 16'h0000, 2'b00, lat, err, rd);
    check("rd5_latency", lat, 32'd2);
    check("rd5_data", {16'd0, rd}, 32'h0000_A5C3);
    check("rd5_err", {31'd0, err}, 32'd0);

    do_req(0, 1'b1, 9'd7, 16'hFFFF, 2'b11, lat, err, rd);
    do_req(0, 1'b1, 9'd7, 16'h1234, 2'b01, lat, err, rd);
    do_req(0, 1'b0, 9'd7, 16'h0000, 2'b00, lat, err, rd);
    check("be_low", {16'd0, rd}, 32'h0000_FF34);
    do_req(0, 1'b1, 9'd7, 16'h0000, 2'b00, lat, err, rd);
    do_req(0, 1'b1, 9'd7, 16'hABCD, 2'b10, lat, err, rd);
    check("wr_keeps_rdata", {16'd0, bus.rdata[0 +: W]}, 32'h0000_FF34);
    do_req(0, 1'b0, 9'd7, 16'h0000, 2'b11, lat, err, rd);
    check("be_high_and_zero", {16'd0, rd}, 32'h0000_AB34);

    do_req(0, 1'b1, 9'd1, 16'h1111, 2'b11, lat, err, rd);
    do_req(0, 1'b1, 9'd2, 16'h2222, 2'b11, lat, err, rd);
    do_req(1, 1'b0, 9'd5, 16'h0000, 2'b00, lat, err, rd);
    check("ch1_rd5", {16'd0, rd}, 32'h0000_A5C3);
    check("ch0_rdata_untouched", {16'd0, bus.rdata[0 +: W]}, 32'h0000_AB34);

    // Both channels request continuously; last grant was channel 1.
    bus.wr_rd = 2'b00;
    bus.addr  = {9'd2, 9'd1};
    bus.valid = 2'b11;
    n_done = 0;
    for (cyc = 1; cyc <= 40 && n_done < 4; cyc++) begin
      @(posedge clk_i); #1;
      if (bus.ready[0]) begin order[n_done] = 0; when[n_done] = cyc; n_done++; end
      else if (bus.ready[1]) begin order[n_done] = 1; when[n_done] = cyc; n_done++; end
    end
    bus.valid = 2'b00;
    check("arb_count", n_done, 32'd4);
    check("arb_g0", order[0], 32'd0);
    check("arb_g1", order[1], 32'd1);
    check("arb_g2", order[2], 32'd0);
    check("arb_g3", order[3], 32'd1);
    check("arb_gap01", when[1] - when[0], 32'd3);
    check("arb_gap12", when[2] - when[1], 32'd3);
    check("arb_gap23", when[3] - when[2], 32'd3);
    check("arb_rd_ch0", {16'd0, bus.rdata[0 +: W]}, 32'h0000_1111);
    check("arb_rd_ch1", {16'd0, bus.rdata[W +: W]}, 32'h0000_2222);
    @(posedge clk_i); #1;

    do_req(0, 1'b1, 9'd510, 16'h5555, 2'b11, lat, err, rd);
    check("oor_wr_err", {31'd0, err}, 32'd1);
    check("oor_wr_latency", lat, 32'd2);
    do_req(0, 1'b0, 9'd510, 16'h0000, 2'b00, lat, err, rd);
    check("oor_rd_err", {31'd0, err}, 32'd1);
    check("oor_rd_data", {16'd0, rd}, 32'd0);
    do_req(1, 1'b1, 9'd500, 16'h6666, 2'b11, lat, err, rd);
    check("oor_500_err", {31'd0, err}, 32'd1);
    do_req(0, 1'b0, 9'd5, 16'h0000, 2'b00, lat, err, rd);
    check("oor_mem_intact", {16'd0, rd}, 32'h0000_A5C3);
    do_req(0, 1'b1, 9'd499, 16'h7777, 2'b11, lat, err, rd);
    check("last_addr_wr_err", {31'd0, err}, 32'd0);
    do_req(0, 1'b0, 9'd499, 16'h0000, 2'b00, lat, err, rd);
    check("last_addr_rd", {16'd0, rd}, 32'h0000_7777);

    // Abort a write while it is still in its wait state.
    do_req(0, 1'b1, 9'd3, 16'h0001, 2'b11, lat, err, rd);
    bus.valid[0]      = 1'b1;
    bus.wr_rd[0]      = 1'b1;
    bus.addr[0 +: AW] = 9'd3;
    bus.wdata[0 +: W] = 16'hBEEF;
    bus.be[0 +: BW]   = 2'b11;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    check("abort_ready", {30'd0, bus.ready}, 32'd0);
    check("abort_rdata", {16'd0, bus.rdata[0 +: W]}, 32'd0);
    bus.valid = 2'b00;
    saw_ready = 1'b0;
    repeat (2) begin @(posedge clk_i); #1; saw_ready |= |bus.ready; end
    rst_i = 1'b1;
    wait_clear();
    repeat (4) begin @(posedge clk_i); #1; saw_ready |= |bus.ready; end
    check("abort_no_pulse", {31'd0, saw_ready}, 32'd0);
    do_req(0, 1'b0, 9'd3, 16'h0000, 2'b00, lat, err, rd);
`ifdef MEM_CLEAR_EN
    check("abort_addr3_cleared", {16'd0, rd}, 32'd0);
`else
    check("abort_addr3_kept", {16'd0, rd}, 32'h0000_0001);
`endif

`ifdef MEM_CLEAR_EN
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    bus.valid[0]      = 1'b1;
    bus.wr_rd[0]      = 1'b0;
    bus.addr[0 +: AW] = 9'd7;
    rst_i = 1'b1;
    lat = 0;
    for (int i = 0; i < BOUND; i++) begin
      @(posedge clk_i); #1;
      lat++;
      if (bus.ready[0]) break;
    end
    check("clr_held_off", {31'd0, (lat >= DEPTH)}, 32'd1);
    check("clr_ready", {31'd0, bus.ready[0]}, 32'd1);
    check("clr_rd7", {16'd0, bus.rdata[0 +: W]}, 32'd0);
    bus.valid = 2'b00;
    @(posedge clk_i); #1;
    do_req(1, 1'b0, 9'd499, 16'h0000, 2'b00, lat, err, rd);
    check("clr_rd499", {16'd0, rd}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
